// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: LEGv8 opcodes, ALUControl encoding, FIFO entry layout and opcode decode for alu_issue
package alu_issue_pkg;
  localparam int XLEN = 64;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_ctrl_t;
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
  } fifo_entry_t;
  typedef struct packed {
    alu_ctrl_t ctrl;
    logic      illegal;
  } decode_t;
  function automatic decode_t decode(input logic [10:0] op);
    casez (op)
      OP_ADD, OP_LDUR, OP_STUR: return '{ALU_ADD, 1'b0};
      OP_SUB:                   return '{ALU_SUB, 1'b0};
      OP_AND:                   return '{ALU_AND, 1'b0};
      OP_ORR:                   return '{ALU_ORR, 1'b0};
      11'b10110100???:          return '{ALU_PASSB, 1'b0};
      default:                  return '{ALU_AND, 1'b1};
    endcase
  endfunction
endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: sync FIFO of T entries; ports clk, reset, push/push_data, pop, head, count
module alu_issue_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count < CW'(DEPTH) || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= push_data;
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: issues LEGv8 ops to an external ALU and queues results; ports: in_* request, alu_* ALU link, out_* result, err_mismatch; optional checker macro ALU_ISSUE_CHECK_EN
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [10:0]  in_opcode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_zero,
  output logic         out_illegal,
  output logic         err_mismatch
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic accept, ill_q, pop;
  fifo_entry_t push_data, head;
  decode_t dec;
  assign dec = decode(in_opcode);
  // credit counts the in-flight op so its capture can never overflow the FIFO
  assign in_ready = (count + CW'(state == EXEC)) < CW'(DEPTH);
  assign accept = in_valid && in_ready;
  always_comb state_nx = accept ? EXEC : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_control <= ALU_AND;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_a <= in_a;
        alu_b <= in_b;
        alu_control <= dec.ctrl;
        ill_q <= dec.illegal;
      end
    end
  end
  assign push_data = ill_q ? '{result: '0, zero: 1'b1, illegal: 1'b1}
                           : '{result: XLEN'(alu_result), zero: alu_zero, illegal: 1'b0};
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  alu_issue_fifo #(.DEPTH(DEPTH), .T(fifo_entry_t)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (state == EXEC),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );
  assign out_result = out_valid ? head.result[N-1:0] : '0;
  assign out_zero = out_valid && head.zero;
  assign out_illegal = out_valid && head.illegal;
`ifdef ALU_ISSUE_CHECK_EN
  logic [N-1:0] ref_result;
  always_comb
    ref_result = alu_control == ALU_AND ? alu_a & alu_b :
                 alu_control == ALU_ORR ? alu_a | alu_b :
                 alu_control == ALU_ADD ? alu_a + alu_b :
                 alu_control == ALU_SUB ? alu_a - alu_b : alu_b;
  always_ff @(posedge clk) begin
    if (reset) err_mismatch <= 1'b0;
    else if (state == EXEC && !ill_q && (ref_result != alu_result || (ref_result == '0) != alu_zero))
      err_mismatch <= 1'b1;
  end
`else
  assign err_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue with a behavioural 64-bit ALU
module tb_alu_issue;
  logic clk = 0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal, err_mismatch;
  logic alu_zero, force_bad;
  logic [10:0] in_opcode;
  logic [63:0] in_a, in_b, alu_a, alu_b, alu_result, true_result, out_result;
  logic [3:0] alu_control;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .err_mismatch(err_mismatch)
  );
  assign true_result = alu_control == 4'b0000 ? alu_a & alu_b :
                       alu_control == 4'b0001 ? alu_a | alu_b :
                       alu_control == 4'b0010 ? alu_a + alu_b :
                       alu_control == 4'b0110 ? alu_a - alu_b : alu_b;
  assign alu_result = true_result ^ {63'b0, force_bad};
  assign alu_zero = true_result == 64'd0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1;
    in_opcode = op;
    in_a = a;
    in_b = b;
  endtask
  initial begin
    reset = 1; in_valid = 0; out_ready = 0; force_bad = 0;
    in_opcode = '0; in_a = '0; in_b = '0;
    step(); step();
    reset = 0;
    chk("rst_ctrl", alu_control, 4'b0000);
    chk("rst_a", alu_a, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_oresult", out_result, 0);
    chk("rst_iready", in_ready, 1);
    chk("rst_err", err_mismatch, 0);
    issue(11'b10001011000, 239, 26);
    step();
    in_valid = 0;
    chk("add_ctrl", alu_control, 4'b0010);
    chk("add_a", alu_a, 239);
    chk("add_ovalid_early", out_valid, 0);
    step();
    chk("add_ovalid", out_valid, 1);
    chk("add_result", out_result, 265);
    chk("add_zero", out_zero, 0);
    chk("add_illegal", out_illegal, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("add_popped", out_valid, 0);
    chk("empty_result", out_result, 0);
    out_ready = 1;
    issue(11'b11001011000, 593, 593);
    step();
    chk("sub_ready", in_ready, 1);
    issue(11'b10001010000, -98, -407);
    step();
    in_valid = 0;
    chk("sub_valid", out_valid, 1);
    chk("sub_result", out_result, 0);
    chk("sub_zero", out_zero, 1);
    chk("and_ctrl", alu_control, 4'b0000);
    step();
    chk("and_valid", out_valid, 1);
    chk("and_result", out_result, -504);
    chk("and_zero", out_zero, 0);
    step();
    chk("and_drained", out_valid, 0);
    out_ready = 0;
    issue(11'b10110100101, 930, 0);
    step();
    in_valid = 0;
    chk("cbz_ctrl", alu_control, 4'b0111);
    step();
    chk("cbz0_result", out_result, 0);
    chk("cbz0_zero", out_zero, 1);
    chk("cbz0_illegal", out_illegal, 0);
    out_ready = 1; step(); out_ready = 0;
    issue(11'b10110100101, 930, -33);
    step();
    in_valid = 0;
    step();
    chk("cbz1_result", out_result, -33);
    chk("cbz1_zero", out_zero, 0);
    out_ready = 1; step(); out_ready = 0;
    issue(11'b10101010000, 5, 10);
    step();
    chk("bp_ready1", in_ready, 1);
    in_a = 16; in_b = 1;
    step();
    chk("bp_ready2", in_ready, 0);
    in_a = 32; in_b = 2;
    step();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head1", out_result, 15);
    step();
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_ctrl_a", alu_a, 16);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_pop_ready", in_ready, 1);
    chk("bp_head2", out_result, 17);
    step();
    in_valid = 0;
    chk("bp_acc3_a", alu_a, 32);
    chk("bp_acc3_ready", in_ready, 0);
    step();
    chk("bp_hold_head2", out_result, 17);
    out_ready = 1;
    step();
    chk("bp_head3", out_result, 34);
    step();
    chk("bp_drained", out_valid, 0);
    out_ready = 0;
    issue(11'b00000000000, 7, 9);
    step();
    in_valid = 0;
    chk("ill_ctrl", alu_control, 4'b0000);
    step();
    chk("ill_flag", out_illegal, 1);
    chk("ill_result", out_result, 0);
    chk("ill_zero", out_zero, 1);
    chk("ill_err", err_mismatch, 0);
    out_ready = 1; step(); out_ready = 0;
    chk("clean_err", err_mismatch, 0);
    force_bad = 1;
    issue(11'b10001011000, 1, 2);
    step();
    in_valid = 0;
    step();
    force_bad = 0;
`ifdef ALU_ISSUE_CHECK_EN
    chk("bad_err", err_mismatch, 1);
    out_ready = 1; step(); out_ready = 0;
    chk("bad_err_sticky", err_mismatch, 1);
`else
    chk("bad_err_off", err_mismatch, 0);
    out_ready = 1; step(); out_ready = 0;
`endif
    issue(11'b10001011000, 3, 4);
    step();
    in_valid = 0;
    step();
    chk("rs_pre_valid", out_valid, 1);
    issue(11'b10001011000, 5, 6);
    step();
    in_valid = 0;
    reset = 1;
    step();
    reset = 0;
    chk("rs_valid", out_valid, 0);
    chk("rs_ready", in_ready, 1);
    chk("rs_ctrl", alu_control, 4'b0000);
    chk("rs_result", out_result, 0);
    chk("rs_err", err_mismatch, 0);
    step();
    chk("rs_no_stale", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
